// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
//   Captures a 4-digit packed BCD value on a load strobe and scans it onto a
//   time-multiplexed seven-segment display. Includes a refresh divider,
//   leading-zero blanking, flagging of invalid digits and a capture acknowledge.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   bcd_in  in   [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
//   load    in   capture bcd_in at this edge
//   seg     out  segments {a,b,c,d,e,f,g}, seg[6] = a (polarity set by SEG_ACTIVE_LOW)
//   an      out  digit enables, active-low, an[0] = ones digit
//   err     out  captured value holds a nibble greater than 9
//   ack     out  one-cycle pulse after each capture
module bcd_seg_scan #(
    parameter int unsigned REFRESH_DIV    = 4,
    parameter bit          BLANK_LZ       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err,
    output logic        ack
);

    // A divide-by-one still needs a one-bit counter that simply stays at 0.
    localparam int unsigned     DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    logic [15:0]      shadow;
    logic [1:0]       idx;
    logic [DIV_W-1:0] div;

    logic [3:0]       nibble;
    logic             blank;
    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = 7'b0000001;
        endcase
    endfunction

    function automatic logic has_invalid(input logic [15:0] v);
        has_invalid = (v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
                      (v[7:4]   > 4'd9) || (v[3:0]  > 4'd9);
    endfunction

    always_comb begin
        nibble = shadow[3:0];
        blank  = 1'b0;
        case (idx)
            2'd0: nibble = shadow[3:0];
            2'd1: nibble = shadow[7:4];
            2'd2: nibble = shadow[11:8];
            2'd3: nibble = shadow[15:12];
            default: nibble = shadow[3:0];
        endcase
        // A digit is a leading zero when it and every more significant nibble
        // are zero; invalid nibbles are non-zero and therefore stop blanking.
        if (BLANK_LZ) begin
            case (idx)
                2'd1:    blank = (shadow[15:4] == 12'h000);
                2'd2:    blank = (shadow[15:8] == 8'h00);
                2'd3:    blank = (shadow[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
        if (blank) begin
            seg_nxt = SEG_OFF;
            an_nxt  = 4'b1111;
        end else begin
            seg_nxt = SEG_ACTIVE_LOW ? ~seg_decode(nibble) : seg_decode(nibble);
            an_nxt  = ~(4'b0001 << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= 16'h0000;
            idx    <= 2'd0;
            div    <= '0;
            seg    <= SEG_OFF;
            an     <= 4'b1111;
            err    <= 1'b0;
            ack    <= 1'b0;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
            ack <= load;
            if (load) begin
                shadow <= bcd_in;
                err    <= has_invalid(bcd_in);
            end
            if (div == DIV_LAST) begin
                div <= '0;
                idx <= idx + 2'd1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] bcd_in;

    logic [6:0] seg_o [3];
    logic [3:0] an_o  [3];
    logic       err_o [3];
    logic       ack_o [3];

    always #5 clk = ~clk;

    // Config 0: defaults. Config 1: no blanking. Config 2: REFRESH_DIV = 1.
    bcd_seg_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
        .seg(seg_o[0]), .an(an_o[0]), .err(err_o[0]), .ack(ack_o[0]));
    bcd_seg_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
        .seg(seg_o[1]), .an(an_o[1]), .err(err_o[1]), .ack(ack_o[1]));
    bcd_seg_scan #(.REFRESH_DIV(1), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
        .seg(seg_o[2]), .an(an_o[2]), .err(err_o[2]), .ack(ack_o[2]));

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       err;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    int unsigned cfg_div [3] = '{4, 4, 1};
    bit          cfg_blz [3] = '{1'b1, 1'b0, 1'b1};

    logic [15:0] m_sh;
    logic        m_err;
    int          m_idx [3];
    int          m_div [3];

    // Segment patterns as printed on the display (lit = 0).
    function automatic logic [6:0] lit_pattern(input logic [3:0] n);
        logic [6:0] t [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
                               7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
        return t[n];
    endfunction

    function automatic logic bad_digit(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, predict the outputs after the edge, then compare.
    task automatic step(input logic r, input logic l, input logic [15:0] b);
        exp_t e;
        logic [3:0] nib;
        bit         blanked;
        reset  = r;
        load   = l;
        bcd_in = b;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                e = '{seg: 7'b1111111, an: 4'b1111, err: 1'b0, ack: 1'b0};
            end else begin
                nib     = 4'((m_sh >> (4 * m_idx[k])) & 16'hF);
                blanked = 1'b0;
                if (cfg_blz[k] && m_idx[k] != 0)
                    blanked = ((m_sh >> (4 * m_idx[k])) == 16'h0);
                e.seg = blanked ? 7'b1111111 : lit_pattern(nib);
                e.an  = blanked ? 4'b1111 : 4'b1111 & ~(4'b0001 << m_idx[k]);
                e.err = l ? bad_digit(b) : m_err;
                e.ack = l;
            end
            exp_q.push_back(e);
        end
        if (r) begin
            m_sh = 16'h0;
            m_err = 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_idx[k] = 0;
                m_div[k] = 0;
            end
        end else begin
            if (l) begin
                m_sh  = b;
                m_err = bad_digit(b);
            end
            for (int k = 0; k < 3; k++) begin
                if (m_div[k] + 1 >= int'(cfg_div[k])) begin
                    m_div[k] = 0;
                    m_idx[k] = (m_idx[k] + 1) % 4;
                end else begin
                    m_div[k] = m_div[k] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("seg[%0d]", k), 16'(seg_o[k]), 16'(e.seg));
            chk($sformatf("an[%0d]", k),  16'(an_o[k]),  16'(e.an));
            chk($sformatf("err[%0d]", k), 16'(err_o[k]), 16'(e.err));
            chk($sformatf("ack[%0d]", k), 16'(ack_o[k]), 16'(e.ack));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; bcd_in = 16'h0;
        m_sh = 16'h0; m_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0;
            m_div[k] = 0;
        end
        @(negedge clk);

        // 1: reset, single-cycle load of 0017, two full scan rounds
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("rst_an",  16'(an_o[0]),  16'h000F);
        chk("rst_seg", 16'(seg_o[0]), 16'h007F);
        step(1'b0, 1'b1, 16'h0017);
        chk("t1_ack_hi", 16'(ack_o[0]), 16'h1);
        step(1'b0, 1'b0, 16'h0);
        chk("t1_ack_lo", 16'(ack_o[0]), 16'h0);
        chk("t1_d0_seg", 16'(seg_o[0]), 16'h000F);
        chk("t1_d0_an",  16'(an_o[0]),  16'h000E);
        idle(32);

        // 2: 0255, digit3 blanked
        step(1'b0, 1'b1, 16'h0255);
        idle(17);

        // 3: all zero; config 1 shows every digit
        step(1'b0, 1'b1, 16'h0000);
        idle(17);

        // 4: invalid nibble, then recovery
        step(1'b0, 1'b1, 16'h1A05);
        chk("t4_err", 16'(err_o[0]), 16'h1);
        idle(17);
        step(1'b0, 1'b1, 16'h0005);
        chk("t4_err_clr", 16'(err_o[0]), 16'h0);
        idle(4);

        // 5: reset mid-dwell on digit 2
        while (m_idx[0] != 2 || m_div[0] != 1) idle(1);
        step(1'b1, 1'b0, 16'h0);
        chk("t5_an",  16'(an_o[0]),  16'h000F);
        chk("t5_ack", 16'(ack_o[0]), 16'h0);
        idle(10);

        // 6: reset beats load, then load held three cycles
        step(1'b1, 1'b1, 16'h0999);
        chk("t6_rst_ack", 16'(ack_o[0]), 16'h0);
        step(1'b0, 1'b1, 16'h0001);
        step(1'b0, 1'b1, 16'h0002);
        step(1'b0, 1'b1, 16'h0003);
        chk("t6_ack_held", 16'(ack_o[0]), 16'h1);
        idle(18);

        // REFRESH_DIV = 1 rotation
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 16'h0);
        chk("rot_1101", 16'(an_o[2]), 16'h000D);
        step(1'b0, 1'b0, 16'h0);
        chk("rot_1011", 16'(an_o[2]), 16'h000B);
        step(1'b0, 1'b0, 16'h0);
        chk("rot_0111", 16'(an_o[2]), 16'h0007);
        step(1'b0, 1'b0, 16'h0);
        chk("rot_1110", 16'(an_o[2]), 16'h000E);
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
